// File: rtl/mmio_io_ctrl.sv
// rtl/mmio_io_ctrl.sv - memory-mapped LED/hex/switch/timer slave for the upper half of the CPU address space
module mmio_io_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PRESCALE        = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    input  logic [7:0]  sw,
    output logic [7:0]  led,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        bad_addr
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

    localparam logic [8:0] ADDR_LED   = 9'h100;
    localparam logic [8:0] ADDR_HEX   = 9'h120;
    localparam logic [8:0] ADDR_SW    = 9'h140;
    localparam logic [8:0] ADDR_TIMER = 9'h160;

    logic [15:0]   hex_val;
    logic [15:0]   timer;
    logic [PW-1:0] pcnt;
    logic [7:0]    s1, s2, candidate, sw_db;
    logic [CW-1:0] cnt;

    logic        rd_cmd, wr_cmd, mapped, tick;
    logic [15:0] rd_mux;

    assign rd_cmd = (mem_cmd == 2'b01) && mem_addr[8];
    assign wr_cmd = (mem_cmd == 2'b10) && mem_addr[8];
    assign mapped = (mem_addr == ADDR_LED) || (mem_addr == ADDR_HEX) ||
                    (mem_addr == ADDR_SW)  || (mem_addr == ADDR_TIMER);
    assign tick   = (pcnt == PCNT_LAST);

    always_comb begin
        rd_mux = 16'h0000;
        case (mem_addr)
            ADDR_LED:   rd_mux = {8'h00, led};
            ADDR_HEX:   rd_mux = hex_val;
            ADDR_SW:    rd_mux = {8'h00, sw_db};
            ADDR_TIMER: rd_mux = timer;
            default:    rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led       <= 8'h00;
            hex_val   <= 16'h0000;
            timer     <= 16'h0000;
            pcnt      <= '0;
            s1        <= 8'h00;
            s2        <= 8'h00;
            candidate <= 8'h00;
            cnt       <= '0;
            sw_db     <= 8'h00;
            rd_data   <= 16'h0000;
            rd_valid  <= 1'b0;
            bad_addr  <= 1'b0;
        end else begin
            s1 <= sw;
            s2 <= s1;
            if (s2 != candidate) begin
                candidate <= s2;
                cnt       <= '0;
            end else if (cnt == CNT_LAST) begin
                sw_db <= candidate;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // A TIMER write overrides a coincident prescaler tick.
            if (wr_cmd && mem_addr == ADDR_TIMER) begin
                timer <= write_data;
                pcnt  <= '0;
            end else if (tick) begin
                timer <= timer + 16'd1;
                pcnt  <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end

            if (wr_cmd && mem_addr == ADDR_LED) led     <= write_data[7:0];
            if (wr_cmd && mem_addr == ADDR_HEX) hex_val <= write_data;

            rd_valid <= rd_cmd;
            if (rd_cmd) rd_data <= rd_mux;
            bad_addr <= (rd_cmd || wr_cmd) && !mapped;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign hex0 = seg7(hex_val[3:0]);
    assign hex1 = seg7(hex_val[7:4]);
    assign hex2 = seg7(hex_val[11:8]);
    assign hex3 = seg7(hex_val[15:12]);

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// tb/tb_mmio_io_ctrl.sv - directed self-checking bench for mmio_io_ctrl
module tb_mmio_io_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] write_data;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        bad_addr;

    int tests = 0;
    int fails = 0;

    mmio_io_ctrl #(.DEBOUNCE_CYCLES(4), .PRESCALE(50)) dut (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .write_data(write_data), .sw(sw), .led(led),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .rd_data(rd_data), .rd_valid(rd_valid), .bad_addr(bad_addr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [1:0] cmd, input logic [8:0] addr, input logic [15:0] data);
        mem_cmd    = cmd;
        mem_addr   = addr;
        write_data = data;
        step();
        mem_cmd = 2'b00;
    endtask

    initial begin
        reset = 1'b1; mem_cmd = 2'b00; mem_addr = 9'h000; write_data = 16'h0000; sw = 8'h00;
        step(); step();
        reset = 1'b0;

        check("reset_led", {8'h00, led}, 16'h0000);
        check("reset_rd_valid", {15'h0, rd_valid}, 16'h0000);
        check("reset_bad_addr", {15'h0, bad_addr}, 16'h0000);
        check("reset_hex0", {9'h0, hex0}, {9'h0, 7'b1000000});
        check("reset_hex3", {9'h0, hex3}, {9'h0, 7'b1000000});
        bus(2'b01, 9'h160, 16'h0);
        check("reset_timer_rd", rd_data, 16'h0000);
        check("reset_timer_valid", {15'h0, rd_valid}, 16'h0001);

        bus(2'b10, 9'h120, 16'hABCD);
        check("hex3_A", {9'h0, hex3}, {9'h0, 7'b0001000});
        check("hex2_b", {9'h0, hex2}, {9'h0, 7'b0000011});
        check("hex1_C", {9'h0, hex1}, {9'h0, 7'b1000110});
        check("hex0_d", {9'h0, hex0}, {9'h0, 7'b0100001});
        bus(2'b01, 9'h120, 16'h0);
        check("hex_rd", rd_data, 16'hABCD);
        check("hex_rd_valid", {15'h0, rd_valid}, 16'h0001);
        step();
        check("rd_valid_one_cycle", {15'h0, rd_valid}, 16'h0000);
        check("rd_data_hold", rd_data, 16'hABCD);

        bus(2'b10, 9'h100, 16'h1234);
        check("led_write", {8'h00, led}, 16'h0034);
        bus(2'b01, 9'h100, 16'h0);
        check("led_rd", rd_data, 16'h0034);
        bus(2'b01, 9'h0FF, 16'h0);
        check("ram_side_valid", {15'h0, rd_valid}, 16'h0000);
        check("ram_side_hold", rd_data, 16'h0034);
        check("ram_side_bad", {15'h0, bad_addr}, 16'h0000);
        bus(2'b11, 9'h100, 16'h0);
        check("cmd11_valid", {15'h0, rd_valid}, 16'h0000);

        // Switch debounce: sw_db must still be 0 after edge 6, set after edge 7.
        sw = 8'h5A;
        repeat (6) step();
        bus(2'b01, 9'h140, 16'h0);
        check("sw_db_not_early", rd_data, 16'h0000);
        bus(2'b01, 9'h140, 16'h0);
        check("sw_db_edge7", rd_data, 16'h005A);

        sw = 8'hFF;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) sw = 8'h5A;
            bus(2'b01, 9'h140, 16'h0);
            check($sformatf("sw_glitch_%0d", i), rd_data, 16'h005A);
        end

        bus(2'b10, 9'h140, 16'h00FF);
        check("sw_write_no_bad", {15'h0, bad_addr}, 16'h0000);
        bus(2'b01, 9'h140, 16'h0);
        check("sw_write_ignored", rd_data, 16'h005A);

        // Timer wrap: the 50th clock after the load is the tick.
        bus(2'b10, 9'h160, 16'hFFFF);
        repeat (49) step();
        bus(2'b01, 9'h160, 16'h0);
        check("timer_pre_tick", rd_data, 16'hFFFF);
        bus(2'b01, 9'h160, 16'h0);
        check("timer_wrap", rd_data, 16'h0000);

        bus(2'b10, 9'h160, 16'hFFFF);
        repeat (49) step();
        bus(2'b10, 9'h160, 16'h0010);
        bus(2'b01, 9'h160, 16'h0);
        check("timer_write_wins", rd_data, 16'h0010);

        bus(2'b01, 9'h1F0, 16'h0);
        check("bad_rd_data", rd_data, 16'h0000);
        check("bad_rd_valid", {15'h0, rd_valid}, 16'h0001);
        check("bad_rd_pulse", {15'h0, bad_addr}, 16'h0001);
        step();
        check("bad_pulse_end", {15'h0, bad_addr}, 16'h0000);
        bus(2'b10, 9'h1F0, 16'h1111);
        check("bad_wr_pulse", {15'h0, bad_addr}, 16'h0001);

        reset = 1'b1;
        bus(2'b01, 9'h120, 16'h0);
        reset = 1'b0;
        check("reset_mid_read_valid", {15'h0, rd_valid}, 16'h0000);
        check("reset_mid_read_data", rd_data, 16'h0000);
        check("reset_hex_clear", {9'h0, hex2}, {9'h0, 7'b1000000});
        bus(2'b01, 9'h100, 16'h0);
        check("reset_led_rd", rd_data, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mmio_io_ctrl.md
Name: mmio_io_ctrl

Overview:
- Memory-mapped I/O slave for the upper half of the 9-bit CPU address space (mem_addr[8]=1); the RAM owns mem_addr[8]=0.
- Sits beside the RAM on the CPU memory bus and decodes the same mem_cmd/mem_addr/write_data signals.
- Provides an LED register, a hex-display register with seven-segment decode, debounced switch input, and a prescaled 16-bit timer.
- The top muxes rd_data onto the CPU read_data bus when rd_valid=1. Read latency matches the RAM's one-clock registered dout.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required before sw_db updates (>=1).
- PRESCALE, 50, clocks per timer increment (>=1).

Ports:
- clk  input  1  rising-edge clock (~KEY[0] at top)
- reset  input  1  synchronous, active-high
- mem_cmd  input  2  00 none, 01 read, 10 write, 11 treated as none
- mem_addr  input  9  bus address
- write_data  input  16  write payload
- sw  input  8  raw asynchronous switches SW[7:0]
- led  output  8  LED register
- hex0..hex3  output  7 each  active-low segments; bit0=a … bit6=g; hex0 = nibble [3:0] … hex3 = nibble [15:12]
- rd_data  output  16  registered read data
- rd_valid  output  1  high for the one cycle after an accepted read
- bad_addr  output  1  one-cycle pulse after any read or write to an unmapped upper address

Behaviour:
- Select: sel = mem_addr[8]. Commands with sel=0, or with mem_cmd of 00 or 11, are ignored entirely.
- Register map (full 9-bit address match):
  - 0x100 LED (R/W): write sets led ← write_data[7:0]; read returns {8'h00, led}.
  - 0x120 HEX (R/W): write sets hex_val ← write_data; read returns hex_val.
  - 0x140 SW (RO): read returns {8'h00, sw_db}; writes are ignored and do NOT raise bad_addr.
  - 0x160 TIMER (R/W): write loads timer ← write_data and clears the prescale counter; read returns timer.
  - Any other sel=1 address: read returns 16'h0000; write has no effect; bad_addr pulses on the next cycle.
- Writes take effect at the clock edge where mem_cmd=10 with a matching address.
- Read timing:
  - At an edge with mem_cmd=01 and sel=1: rd_data ← the selected value as it was before that edge; rd_valid ← 1.
  - Otherwise rd_valid ← 0 and rd_data holds its last value.
- Switch path:
  - Two-flop synchronizer: sw → s1 → s2.
  - Debounce counter: if s2 ≠ candidate, candidate ← s2 and cnt ← 0. Otherwise, if cnt = DEBOUNCE_CYCLES−1, sw_db ← candidate; else cnt increments (saturating).
  - Bounce that reverts within fewer than DEBOUNCE_CYCLES stable samples never reaches sw_db.
- Timer:
  - pcnt counts 0..PRESCALE−1 and wraps.
  - On wrap, timer increments modulo 2^16 (16'hFFFF → 16'h0000).
  - A TIMER write in the same cycle as a tick wins: timer = written value, pcnt = 0.
  - A read in the same cycle as a tick returns the pre-increment value.
- Seven-segment decode: combinational from hex_val, standard 0-F glyphs, active-low.
  - 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000, A = 7'b0001000, F = 7'b0001110.
- Reset (synchronous, any cycle, including mid-read): clears to 0 the following:
  - led, hex_val, timer, pcnt, s1, s2, candidate, cnt, sw_db, rd_data, rd_valid, bad_addr.
  - hex0..hex3 therefore show 7'b1000000.
  - A read or write presented in the reset cycle is discarded.

Test Plan:
- Reset → led=8'h00, rd_valid=0, hex0..hex3=7'b1000000, timer read (next cycle) = 16'h0000.
- Write 16'hABCD to 0x120 → hex3=7'b0001000 (A), hex0=7'b0100001 (d); read 0x120 → next cycle rd_data=16'hABCD, rd_valid=1 for exactly one cycle.
- Write 16'h1234 to 0x100 → led=8'h34; read 0x100 → rd_data=16'h0034; same read with mem_addr=0x0FF (RAM side) → rd_valid stays 0.
- sw=8'h5A held → sw_db=8'h5A after 2+DEBOUNCE_CYCLES+1 clocks (DEBOUNCE_CYCLES=4: cycle 7, not earlier); 2-cycle glitch to 8'hFF then back → sw_db unchanged.
- PRESCALE=50: write 16'hFFFF to 0x160; after 50 clocks read → 16'h0000; write 16'h0010 on the exact tick cycle → timer=16'h0010 with no increment.
- Read 0x1F0 → rd_data=16'h0000, rd_valid=1, bad_addr pulse; write 0x140 → no bad_addr; assert reset during a read → rd_valid=0 next cycle.
